// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L1-to-L2 bus arbiter and its helpers.
package l2_arb_pkg;

  localparam int NUM_CORES = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    DONE = ST_DONE
  } arb_state_t;

  typedef logic core_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
module rr_arb2
  import l2_arb_pkg::*;
(
  input  logic [1:0] req,
  input  core_id_t   last_grant,
  output core_id_t   gnt_id,
  output logic       gnt_any
);

  always_comb begin
    gnt_any = |req;
    gnt_id  = (req == 2'b11) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Serialises two L1 ports onto one L2 port: one access in flight, round-robin grants,
// a one-cycle snoop to the other core per grant, and a watchdog on every L2 access.
module l2_bus_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req_valid  [0:NUM_CORES-1],
  input  logic                  core_req_wr     [0:NUM_CORES-1],
  input  logic [ADDR_WIDTH-1:0] core_req_addr   [0:NUM_CORES-1],
  input  logic [DATA_WIDTH-1:0] core_req_wdata  [0:NUM_CORES-1],
  output logic                  core_resp_valid [0:NUM_CORES-1],
  output logic [DATA_WIDTH-1:0] core_resp_rdata [0:NUM_CORES-1],
  output logic                  core_resp_err   [0:NUM_CORES-1],
  output logic                  snoop_valid     [0:NUM_CORES-1],
  output logic [ADDR_WIDTH-1:0] snoop_addr,
  output logic                  snoop_wr,
  output logic                  l2_req_valid,
  output logic                  l2_req_wr,
  output logic [ADDR_WIDTH-1:0] l2_req_addr,
  output logic [DATA_WIDTH-1:0] l2_req_wdata,
  input  logic                  l2_resp_valid,
  input  logic [DATA_WIDTH-1:0] l2_resp_rdata,
  output logic [1:0]            state_dbg
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t    state;
  core_id_t      owner;
  core_id_t      last_grant;
  core_id_t      gnt_id;
  logic          gnt_any;
  logic [TW-1:0] timer;

  assign state_dbg = state;

  rr_arb2 u_rr_arb2 (
    .req        ({core_req_valid[1], core_req_valid[0]}),
    .last_grant (last_grant),
    .gnt_id     (gnt_id),
    .gnt_any    (gnt_any)
  );

  // Valid handshake: a core holds req_valid with stable fields until it sees its
  // one-cycle resp pulse; L2 sees l2_req_valid held until its one-cycle l2_resp_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= 1'b0;
      last_grant      <= 1'b1;
      timer           <= '0;
      l2_req_valid    <= 1'b0;
      l2_req_wr       <= 1'b0;
      l2_req_addr     <= '0;
      l2_req_wdata    <= '0;
      snoop_valid     <= '{default: 1'b0};
      snoop_addr      <= '0;
      snoop_wr        <= 1'b0;
      core_resp_valid <= '{default: 1'b0};
      core_resp_rdata <= '{default: '0};
      core_resp_err   <= '{default: 1'b0};
    end else begin
      // Snoop and response outputs are single-cycle pulses.
      snoop_valid     <= '{default: 1'b0};
      snoop_addr      <= '0;
      snoop_wr        <= 1'b0;
      core_resp_valid <= '{default: 1'b0};
      core_resp_rdata <= '{default: '0};
      core_resp_err   <= '{default: 1'b0};

      case (state)
        IDLE: begin
          if (gnt_any) begin
            owner               <= gnt_id;
            last_grant          <= gnt_id;
            timer               <= '0;
            l2_req_valid        <= 1'b1;
            l2_req_wr           <= core_req_wr[gnt_id];
            l2_req_addr         <= core_req_addr[gnt_id];
            l2_req_wdata        <= core_req_wdata[gnt_id];
            snoop_valid[~gnt_id] <= 1'b1;
            snoop_addr          <= core_req_addr[gnt_id];
            snoop_wr            <= core_req_wr[gnt_id];
            state               <= REQ;
          end
        end
        REQ: begin
          // A response arriving on the watchdog's last cycle still counts as success.
          if (l2_resp_valid || timer == TIMER_MAX) begin
            state                  <= DONE;
            l2_req_valid           <= 1'b0;
            l2_req_wr              <= 1'b0;
            l2_req_addr            <= '0;
            l2_req_wdata           <= '0;
            core_resp_valid[owner] <= 1'b1;
            core_resp_err[owner]   <= ~l2_resp_valid;
            core_resp_rdata[owner] <= (l2_resp_valid && !l2_req_wr) ? l2_resp_rdata : '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          timer <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
